// File: rtl/btn_conditioner.sv
// Push-button conditioner: per-button 2-flop synchronizer, debounce counter,
// registered debounced level and a one-cycle press strobe.
module btn_conditioner #(
  parameter int unsigned NB_BTN       = 3,
  parameter int unsigned DEBOUNCE_CNT = 1000000
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [NB_BTN-1:0] i_btn,
  output logic [NB_BTN-1:0] o_btn_level,
  output logic [NB_BTN-1:0] o_btn_pulse
);

  // Counter only has to reach DEBOUNCE_CNT-1; keep at least one bit for DEBOUNCE_CNT == 1.
  localparam int unsigned CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT - 1);

  for (genvar g = 0; g < NB_BTN; g++) begin : g_btn
    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      pulse_d = 1'b0;
      if (s2_q != level_q) begin
        if (cnt_q == CNT_MAX) begin
          level_d = s2_q;
          // A mismatch against a low level can only be a press.
          pulse_d = s2_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        cnt_q   <= '0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        s1_q    <= i_btn[g];
        s2_q    <= s1_q;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        pulse_q <= pulse_d;
      end
    end

    assign o_btn_level[g] = level_q;
    assign o_btn_pulse[g] = pulse_q;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed vector table, hold test, and random
// stimulus compared against a run-length reference model.
module tb_btn_conditioner;
  localparam int unsigned NB = 3;
  localparam int unsigned DC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NB-1:0] btn = '0;
  logic [NB-1:0] lvl, pls;

  btn_conditioner #(.NB_BTN(NB), .DEBOUNCE_CNT(DC)) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_btn      (btn),
    .o_btn_level(lvl),
    .o_btn_pulse(pls)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          r;
    logic [NB-1:0] b;
    logic [NB-1:0] el;
    logic [NB-1:0] ep;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: the synchronized view of a button is its raw value two
  // edges earlier; the level flips once the synchronized view has disagreed
  // with it for DC consecutive edges, and a rising flip is a press pulse.
  logic [NB-1:0] raw_q[$];
  logic [NB-1:0] m_lvl = '0;
  logic [NB-1:0] m_pls = '0;
  int            streak[NB];

  task automatic model_edge(input logic r, input logic [NB-1:0] b);
    logic [NB-1:0] sync;
    if (r) begin
      raw_q.delete();
      m_lvl = '0;
      m_pls = '0;
      foreach (streak[i]) streak[i] = 0;
      return;
    end
    sync = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : '0;
    raw_q.push_back(b);
    if (raw_q.size() > 2) void'(raw_q.pop_front());
    m_pls = '0;
    for (int i = 0; i < NB; i++) begin
      if (sync[i] != m_lvl[i]) begin
        streak[i]++;
        if (streak[i] == DC) begin
          m_lvl[i]  = sync[i];
          m_pls[i]  = sync[i];
          streak[i] = 0;
        end
      end else begin
        streak[i] = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [2*NB-1:0] act, input logic [2*NB-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: level/pulse got %b expected %b", name, act, exp);
  endtask

  task automatic step(input logic r, input logic [NB-1:0] b);
    rst = r;
    btn = b;
    @(posedge clk);
    model_edge(r, b);
    #1;
  endtask

  function automatic void add(input logic r, input logic [NB-1:0] b,
                              input logic [NB-1:0] el, input logic [NB-1:0] ep);
    vec_t v;
    v.r = r; v.b = b; v.el = el; v.ep = ep;
    vecs.push_back(v);
  endfunction

  function automatic void add_n(input logic r, input logic [NB-1:0] b, input int n,
                                input logic [NB-1:0] el, input logic [NB-1:0] ep);
    for (int k = 0; k < n; k++) add(r, b, el, ep);
  endfunction

  initial begin
    int pcount;
    logic [NB-1:0] rb;
    logic          rr;

    // Reset
    add_n(1, 3'b000, 2, 3'b000, 3'b000);
    // Clean press of A: level and pulse on the 6th edge, pulse clears while held
    add_n(0, 3'b001, 5, 3'b000, 3'b000);
    add  (0, 3'b001,    3'b001, 3'b001);
    add_n(0, 3'b001, 3, 3'b001, 3'b000);
    add_n(0, 3'b000, 5, 3'b001, 3'b000);
    add  (0, 3'b000,    3'b000, 3'b000);
    // Simultaneous press and release
    add_n(0, 3'b111, 5, 3'b000, 3'b000);
    add  (0, 3'b111,    3'b111, 3'b111);
    add_n(0, 3'b111, 2, 3'b111, 3'b000);
    add_n(0, 3'b000, 5, 3'b111, 3'b000);
    add_n(0, 3'b000, 2, 3'b000, 3'b000);
    // Glitch on opcode button
    add_n(0, 3'b100, 3, 3'b000, 3'b000);
    add_n(0, 3'b000, 6, 3'b000, 3'b000);
    // Bounce on B, then steady press
    add_n(0, 3'b010, 2, 3'b000, 3'b000);
    add_n(0, 3'b000, 2, 3'b000, 3'b000);
    add_n(0, 3'b010, 2, 3'b000, 3'b000);
    add_n(0, 3'b000, 2, 3'b000, 3'b000);
    add_n(0, 3'b010, 5, 3'b000, 3'b000);
    add  (0, 3'b010,    3'b010, 3'b010);
    add_n(0, 3'b010, 2, 3'b010, 3'b000);
    add_n(0, 3'b000, 5, 3'b010, 3'b000);
    add  (0, 3'b000,    3'b000, 3'b000);
    // Reset mid-debounce with A held through it
    add_n(0, 3'b001, 3, 3'b000, 3'b000);
    add  (1, 3'b001,    3'b000, 3'b000);
    add_n(0, 3'b001, 5, 3'b000, 3'b000);
    add  (0, 3'b001,    3'b001, 3'b001);
    add  (0, 3'b001,    3'b001, 3'b000);

    foreach (vecs[k]) begin
      step(vecs[k].r, vecs[k].b);
      check($sformatf("vec%0d", k), {lvl, pls}, {vecs[k].el, vecs[k].ep});
    end

    // Long hold yields exactly one pulse
    step(1, 3'b000);
    pcount = 0;
    for (int k = 0; k < 40; k++) begin
      step(0, 3'b001);
      pcount += int'(pls[0]);
    end
    n_chk++;
    if (pcount == 1 && lvl == 3'b001) n_pass++;
    else $display("FAIL hold_once: pulses %0d level %b expected 1 pulse level 001", pcount, lvl);

    // Randomized stimulus against the model
    rb = 3'b001;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, 9) == 0) rb[i] = ~rb[i];
      rr = ($urandom_range(0, 299) == 0);
      step(rr, rb);
      check($sformatf("rnd%0d", k), {lvl, pls}, {m_lvl, m_pls});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
